// File: rtl/pvr_pkg.sv
// Shared definitions for the PVR VRAM port arbiter: requester ids, bus widths,
// arbiter state encoding and the round-robin pointer advance.
package pvr_pkg;

    localparam int unsigned REQ_ISP = 0;
    localparam int unsigned REQ_TSP = 1;
    localparam int unsigned REQ_RA  = 2;

    localparam int unsigned VRAM_AW = 24;
    localparam int unsigned VRAM_DW = 32;

    typedef enum logic [0:0] {
        ARB_IDLE  = 1'b0,
        ARB_OWNED = 1'b1
    } arb_state_t;

    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/pvr_rr_pick.sv
// Combinational round-robin picker: first requesting index at or after ptr,
// reported both one-hot and as an index.
module pvr_rr_pick #(
    parameter  int unsigned NREQ = 3,
    localparam int unsigned IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] grant,
    output logic [IW-1:0]   idx,
    output logic            any
);

    logic [IW-1:0] j;

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        j     = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            j = IW'((32'(ptr) + k) % NREQ);
            if (!any && req[j]) begin
                any   = 1'b1;
                idx   = j;
                grant = NREQ'(1) << j;
            end
        end
    end

endmodule

// File: rtl/pvr_vram_arb.sv
// Arbitrates the single PVR VRAM port between NREQ fetch blocks with
// round-robin grant, bounded burst lock and fixed-latency read return routing.
module pvr_vram_arb
    import pvr_pkg::*;
#(
    parameter int unsigned NREQ      = 3,
    parameter int unsigned RD_LAT    = 1,
    parameter int unsigned BURST_MAX = 16
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req_rd,
    input  logic [NREQ-1:0]         req_wr,
    input  logic [NREQ-1:0]         req_lock,
    input  logic [NREQ*VRAM_AW-1:0] req_addr,
    input  logic [NREQ*VRAM_DW-1:0] req_wdata,
    output logic [NREQ-1:0]         req_ack,
    output logic [NREQ-1:0]         rd_valid,
    output logic [VRAM_DW-1:0]      rd_data,
    input  logic                    vram_busy,
    output logic                    vram_rd,
    output logic                    vram_wr,
    output logic [VRAM_AW-1:0]      vram_addr,
    output logic [VRAM_DW-1:0]      vram_dout,
    input  logic [VRAM_DW-1:0]      vram_din
);

    localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned CW = $clog2(BURST_MAX + 1);

    arb_state_t             state;
    logic [IW-1:0]          owner;
    logic [IW-1:0]          rr_ptr;
    logic [CW-1:0]          burst_cnt;
    logic [IW-1:0]          vram_id;

    logic [NREQ-1:0]        req_any;
    logic [NREQ-1:0]        pick_grant;
    logic [IW-1:0]          pick_idx;
    logic                   pick_any;
    logic [NREQ-1:0]        owner_oh;
    logic                   others_pend;
    logic                   burst_full;
    logic [IW-1:0]          sel;
    logic                   grant_ok;
    logic                   take;

    logic [RD_LAT-1:0]          tag_v;
    logic [RD_LAT-1:0][IW-1:0]  tag_id;

    assign req_any     = req_rd | req_wr;
    assign owner_oh    = NREQ'(1) << owner;
    assign others_pend = |(req_any & ~owner_oh);
    assign burst_full  = (burst_cnt == CW'(BURST_MAX));

    pvr_rr_pick #(.NREQ(NREQ)) u_pick (
        .req   (req_any),
        .ptr   (rr_ptr),
        .grant (pick_grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    // An owner at its burst limit yields for one cycle whenever someone else waits.
    always_comb begin
        sel      = pick_idx;
        grant_ok = pick_any;
        if (state == ARB_OWNED) begin
            sel      = owner;
            grant_ok = req_any[owner] && !(burst_full && others_pend);
        end
        take    = grant_ok && !vram_busy && !reset;
        req_ack = '0;
        if (take) begin
            req_ack = (state == ARB_OWNED) ? owner_oh : pick_grant;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= ARB_IDLE;
            owner     <= '0;
            rr_ptr    <= '0;
            burst_cnt <= '0;
            vram_rd   <= 1'b0;
            vram_wr   <= 1'b0;
            vram_id   <= '0;
            vram_addr <= '0;
            vram_dout <= '0;
        end else begin
            vram_rd <= take && req_rd[sel] && !req_wr[sel];
            vram_wr <= take && req_wr[sel];
            vram_id <= sel;
            if (take) begin
                vram_addr <= req_addr[sel*VRAM_AW +: VRAM_AW];
                vram_dout <= req_wdata[sel*VRAM_DW +: VRAM_DW];
            end
            if (!vram_busy) begin
                unique case (state)
                    ARB_IDLE: begin
                        if (take) begin
                            if (req_lock[sel]) begin
                                state     <= ARB_OWNED;
                                owner     <= sel;
                                burst_cnt <= CW'(1);
                            end else begin
                                rr_ptr <= IW'(rr_next(32'(sel), NREQ));
                            end
                        end
                    end
                    ARB_OWNED: begin
                        if (take) begin
                            if (!burst_full) begin
                                burst_cnt <= burst_cnt + CW'(1);
                            end
                            if (!req_lock[owner]) begin
                                state     <= ARB_IDLE;
                                burst_cnt <= '0;
                                rr_ptr    <= IW'(rr_next(32'(owner), NREQ));
                            end
                        end else if ((!req_any[owner] && !req_lock[owner]) ||
                                     (burst_full && others_pend)) begin
                            state     <= ARB_IDLE;
                            burst_cnt <= '0;
                            rr_ptr    <= IW'(rr_next(32'(owner), NREQ));
                        end
                    end
                    default: state <= ARB_IDLE;
                endcase
            end
        end
    end

    // Tag pipe starts at the issued strobe so its last stage lines up with vram_din.
    always_ff @(posedge clock) begin
        if (reset) begin
            tag_v    <= '0;
            tag_id   <= '0;
            rd_valid <= '0;
            rd_data  <= '0;
        end else begin
            tag_v[0]  <= vram_rd;
            tag_id[0] <= vram_id;
            for (int unsigned i = 1; i < RD_LAT; i++) begin
                tag_v[i]  <= tag_v[i-1];
                tag_id[i] <= tag_id[i-1];
            end
            rd_valid <= tag_v[RD_LAT-1] ? (NREQ'(1) << tag_id[RD_LAT-1]) : '0;
            if (tag_v[RD_LAT-1]) begin
                rd_data <= vram_din;
            end
        end
    end

    rd_wr_exclusive: assert property (@(posedge clock) disable iff (reset) !(|(req_rd & req_wr)));

endmodule

// File: tb/tb_pvr_vram_arb.sv
// Directed bench for pvr_vram_arb: stimulus table for round-robin issue plus
// hand sequences for bursts, busy stalls and reset with reads in flight.
`timescale 1ns/1ps
module tb_pvr_vram_arb;
    import pvr_pkg::*;

    localparam int unsigned NREQ      = 3;
    localparam int unsigned RD_LAT    = 1;
    localparam int unsigned BURST_MAX = 16;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  req_rd = '0, req_wr = '0, req_lock = '0;
    logic [71:0] req_addr = '0;
    logic [95:0] req_wdata = '0;
    logic [2:0]  req_ack, rd_valid;
    logic [31:0] rd_data, vram_dout;
    logic [31:0] vram_din = '0;
    logic        vram_busy = 1'b0;
    logic        vram_rd, vram_wr;
    logic [23:0] vram_addr;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [1:0]  id;
        logic [31:0] data;
    } rdexp_t;
    rdexp_t exp_q[$];
    rdexp_t mon_e;

    typedef struct {
        logic [2:0] rd;
        logic [2:0] wr;
        logic       busy;
        logic [2:0] ack;
    } vec_t;
    vec_t tbl[12];

    always #5 clock = ~clock;

    pvr_vram_arb #(.NREQ(NREQ), .RD_LAT(RD_LAT), .BURST_MAX(BURST_MAX)) dut (
        .clock     (clock),
        .reset     (reset),
        .req_rd    (req_rd),
        .req_wr    (req_wr),
        .req_lock  (req_lock),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ack   (req_ack),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .vram_busy (vram_busy),
        .vram_rd   (vram_rd),
        .vram_wr   (vram_wr),
        .vram_addr (vram_addr),
        .vram_dout (vram_dout),
        .vram_din  (vram_din)
    );

    // VRAM model with one cycle of read latency; data is a tag plus the address.
    always @(posedge clock) vram_din <= vram_rd ? {8'hA5, vram_addr} : 32'h0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Read return scoreboard: every rd_valid must match the oldest expected read.
    always @(negedge clock) begin
        if (!reset && rd_valid !== 3'b000) begin
            if (exp_q.size() == 0) begin
                chk("stray rd_valid", 64'(rd_valid), 64'h0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("rd_valid id", 64'(rd_valid), 64'(3'b001 << mon_e.id));
                chk("rd_data", 64'(rd_data), 64'(mon_e.data));
            end
        end
    end

    task automatic set_addr(input int i, input logic [23:0] a);
        req_addr[24*i +: 24] = a;
    endtask

    task automatic push_rd(input int i, input logic [23:0] a);
        exp_q.push_back('{2'(i), {8'hA5, a}});
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        req_rd = '0; req_wr = '0; req_lock = '0; vram_busy = 1'b0;
        @(negedge clock);
        @(negedge clock);
        exp_q.delete();
        reset = 1'b0;
    endtask

    task automatic drain(input string name, input int n);
        @(negedge clock);
        req_rd = '0; req_wr = '0; req_lock = '0; vram_busy = 1'b0;
        repeat (n) @(negedge clock);
        chk(name, 64'(exp_q.size()), 64'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]  prev_ack, prev_rd, prev_wr, exp_ack, prev_exp;
        logic [23:0] prev_addr, a;
        logic [31:0] prev_wd, wd;
        int          k, tsp_pend;
        int          cnt[3];

        tbl[0]  = '{3'b000, 3'b000, 1'b0, 3'b000};
        tbl[1]  = '{3'b111, 3'b000, 1'b0, 3'b001};
        tbl[2]  = '{3'b111, 3'b000, 1'b0, 3'b010};
        tbl[3]  = '{3'b111, 3'b000, 1'b0, 3'b100};
        tbl[4]  = '{3'b110, 3'b000, 1'b0, 3'b010};
        tbl[5]  = '{3'b011, 3'b000, 1'b1, 3'b000};
        tbl[6]  = '{3'b011, 3'b000, 1'b0, 3'b001};
        tbl[7]  = '{3'b000, 3'b100, 1'b0, 3'b100};
        tbl[8]  = '{3'b000, 3'b011, 1'b0, 3'b001};
        tbl[9]  = '{3'b100, 3'b010, 1'b0, 3'b010};
        tbl[10] = '{3'b101, 3'b000, 1'b0, 3'b100};
        tbl[11] = '{3'b101, 3'b000, 1'b0, 3'b001};

        do_reset();
        #1;
        chk("reset vram_rd", 64'(vram_rd), 64'h0);
        chk("reset vram_wr", 64'(vram_wr), 64'h0);
        chk("reset vram_addr", 64'(vram_addr), 64'h0);
        chk("reset vram_dout", 64'(vram_dout), 64'h0);
        chk("reset rd_valid", 64'(rd_valid), 64'h0);
        chk("reset rd_data", 64'(rd_data), 64'h0);

        // Table: unlocked round robin, busy gating, writes
        prev_ack = '0; prev_rd = '0; prev_wr = '0; prev_addr = '0; prev_wd = '0;
        for (int s = 0; s < 12; s++) begin
            @(negedge clock);
            req_rd = tbl[s].rd; req_wr = tbl[s].wr; vram_busy = tbl[s].busy; req_lock = '0;
            for (int i = 0; i < 3; i++) begin
                req_addr[24*i +: 24]  = 24'h100000 + 24'(s*16 + i);
                req_wdata[32*i +: 32] = 32'hC0DE0000 + 32'(s*16 + i);
            end
            #1;
            chk($sformatf("tbl%0d ack", s), 64'(req_ack), 64'(tbl[s].ack));
            chk($sformatf("tbl%0d vram_rd", s), 64'(vram_rd), 64'(|(prev_ack & prev_rd & ~prev_wr)));
            chk($sformatf("tbl%0d vram_wr", s), 64'(vram_wr), 64'(|(prev_ack & prev_wr)));
            if (prev_ack != 3'b000)
                chk($sformatf("tbl%0d vram_addr", s), 64'(vram_addr), 64'(prev_addr));
            if ((prev_ack & prev_wr) != 3'b000)
                chk($sformatf("tbl%0d vram_dout", s), 64'(vram_dout), 64'(prev_wd));
            prev_ack = tbl[s].ack; prev_rd = tbl[s].rd; prev_wr = tbl[s].wr;
            for (int i = 0; i < 3; i++) begin
                if (tbl[s].ack[i]) begin
                    prev_addr = 24'h100000 + 24'(s*16 + i);
                    prev_wd   = 32'hC0DE0000 + 32'(s*16 + i);
                    if (tbl[s].rd[i] && !tbl[s].wr[i]) push_rd(i, prev_addr);
                end
            end
        end
        drain("tbl drain", 6);

        // Single read latency: ack n, strobe n+1, rd_valid n+3
        do_reset();
        @(negedge clock);
        req_rd = 3'b001; set_addr(0, 24'h0129F8);
        #1 chk("t1 ack", 64'(req_ack), 64'h1);
        push_rd(0, 24'h0129F8);
        @(negedge clock);
        req_rd = '0;
        #1;
        chk("t1 ack drop", 64'(req_ack), 64'h0);
        chk("t1 vram_rd", 64'(vram_rd), 64'h1);
        chk("t1 vram_addr", 64'(vram_addr), 64'h0129F8);
        @(negedge clock);
        #1;
        chk("t1 strobe 1 cycle", 64'(vram_rd), 64'h0);
        chk("t1 rd_valid early", 64'(rd_valid), 64'h0);
        @(negedge clock);
        #1;
        chk("t1 rd_valid", 64'(rd_valid), 64'h1);
        chk("t1 rd_data", 64'(rd_data), 64'hA50129F8);
        drain("t1 drain", 4);

        // 17-read locked burst, nobody else waiting
        do_reset();
        for (int c = 0; c < 17; c++) begin
            @(negedge clock);
            req_rd = 3'b001; req_lock = (c < 16) ? 3'b001 : 3'b000;
            set_addr(0, 24'h0129F8 + 24'(4*c));
            #1;
            chk($sformatf("t2 ack%0d", c), 64'(req_ack), 64'h1);
            if (c > 0) begin
                chk($sformatf("t2 vram_rd%0d", c), 64'(vram_rd), 64'h1);
                chk($sformatf("t2 addr%0d", c), 64'(vram_addr), 64'(24'h0129F8 + 24'(4*(c-1))));
            end
            if (c >= 3) chk($sformatf("t2 rd_valid%0d", c), 64'(rd_valid), 64'h1);
            push_rd(0, 24'h0129F8 + 24'(4*c));
        end
        for (int c = 17; c < 21; c++) begin
            @(negedge clock);
            req_rd = '0; req_lock = '0;
            #1 chk($sformatf("t2 rd_valid%0d", c), 64'(rd_valid), (c < 20) ? 64'h1 : 64'h0);
        end
        drain("t2 drain", 3);

        // Burst limit: ISP locked, TSP waiting from cycle 0
        do_reset();
        k = 0; tsp_pend = 1;
        for (int c = 0; c < 22; c++) begin
            @(negedge clock);
            req_lock = 3'b001;
            req_rd = {1'b0, tsp_pend[0], 1'b1};
            a = 24'h020000 + 24'(4*k);
            set_addr(0, a); set_addr(1, 24'h030000);
            exp_ack = (c < 16) ? 3'b001 : (c == 16) ? 3'b000 : (c == 17) ? 3'b010 : 3'b001;
            #1 chk($sformatf("t3 ack%0d", c), 64'(req_ack), 64'(exp_ack));
            if (exp_ack[0]) begin push_rd(0, a); k++; end
            if (exp_ack[1]) begin push_rd(1, 24'h030000); tsp_pend = 0; end
        end
        drain("t3 drain", 6);

        // All three unlocked: strict rotation
        do_reset();
        cnt = '{0, 0, 0};
        for (int c = 0; c < 9; c++) begin
            @(negedge clock);
            req_rd = 3'b111;
            for (int i = 0; i < 3; i++) set_addr(i, 24'h040000 + 24'(i*'h1000 + 4*cnt[i]));
            exp_ack = 3'b001 << (c % 3);
            #1 chk($sformatf("t4 ack%0d", c), 64'(req_ack), 64'(exp_ack));
            push_rd(c % 3, 24'h040000 + 24'((c % 3)*'h1000 + 4*cnt[c % 3]));
            cnt[c % 3]++;
        end
        drain("t4 drain", 6);

        // Busy for 3 cycles in the middle of a locked burst
        do_reset();
        k = 0; prev_exp = '0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clock);
            vram_busy = (c >= 3 && c <= 5);
            req_rd = (k < 8) ? 3'b001 : 3'b000;
            req_lock = (k < 7) ? 3'b001 : 3'b000;
            a = 24'h050000 + 24'(4*k);
            set_addr(0, a);
            exp_ack = (c >= 3 && c <= 5) ? 3'b000 : (k < 8) ? 3'b001 : 3'b000;
            #1;
            chk($sformatf("t5 ack%0d", c), 64'(req_ack), 64'(exp_ack));
            chk($sformatf("t5 vram_rd%0d", c), 64'(vram_rd), 64'(prev_exp[0]));
            if (c >= 3 && c <= 5) chk($sformatf("t5 burst_cnt%0d", c), 64'(dut.burst_cnt), 64'd3);
            if (exp_ack[0]) begin push_rd(0, a); k++; end
            prev_exp = exp_ack;
        end
        drain("t5 drain", 6);

        // Reset with two reads in flight
        do_reset();
        @(negedge clock);
        req_rd = 3'b001; set_addr(0, 24'h060000);
        #1 chk("t6 ack0", 64'(req_ack), 64'h1);
        @(negedge clock);
        set_addr(0, 24'h060004);
        #1 chk("t6 ack1", 64'(req_ack), 64'h1);
        @(negedge clock);
        req_rd = '0; reset = 1'b1;
        #1 chk("t6 in flight", 64'(vram_rd), 64'h1);
        @(negedge clock);
        #1;
        chk("t6 vram_rd", 64'(vram_rd), 64'h0);
        chk("t6 vram_addr", 64'(vram_addr), 64'h0);
        chk("t6 rd_valid", 64'(rd_valid), 64'h0);
        chk("t6 rd_data", 64'(rd_data), 64'h0);
        chk("t6 state", 64'(dut.state), 64'(ARB_IDLE));
        chk("t6 rr_ptr", 64'(dut.rr_ptr), 64'h0);
        reset = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clock);
            #1 chk($sformatf("t6 no stale%0d", c), 64'(rd_valid), 64'h0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
